// File: rtl/rv32v_lsc_sequencer_if.sv
// Bus between the vector LSC sequencer and the shared scalar load-store controller.
//   mem_ren / mem_wen  : read / write request, held until the access completes
//   mem_addr           : byte address of the current element
//   mem_store_data     : store element, zero-extended into the low bits
//   mem_load_type      : 0 = LB, 1 = LH, 2 = LW
//   mem_ready          : access completes this cycle
//   mem_rdata          : extended load data, valid with mem_ready
//   mem_mal_addr       : current request is misaligned
// master = sequencer side, slave = LSC side.
interface rv32v_lsc_sequencer_if;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_store_data;
    logic [2:0]  mem_load_type;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_mal_addr;

    modport master (
        output mem_ren, mem_wen, mem_addr, mem_store_data, mem_load_type,
        input  mem_ready, mem_rdata, mem_mal_addr
    );

    modport slave (
        input  mem_ren, mem_wen, mem_addr, mem_store_data, mem_load_type,
        output mem_ready, mem_rdata, mem_mal_addr
    );
endinterface

// File: rtl/rv32v_lsc_sequencer.sv
// Breaks one vector memory instruction into ordered scalar accesses on the LSC.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_start, i_flush      : launch (IDLE only) / abort without done
//   i_mode                : 0 unit-stride, 1 strided, 2 indexed, 3 as unit-stride
//   i_is_store, i_eew     : direction, element width (0 B, 1 H, 2 W)
//   i_base_addr, i_stride : base address, signed byte stride
//   i_addr_wide           : per-lane absolute addresses (indexed mode)
//   i_store_data_wide     : per-lane store data
//   i_ven_lanes           : lane enables
//   o_busy, o_done        : op in progress, one-cycle completion pulse
//   o_err, o_err_lane     : misaligned abort and faulting lane, valid with done
//   o_dload_wide          : assembled load result, disabled lanes stay zero
//   io_lsc                : LSC request/response bus
//
// state  | meaning
// S_IDLE | waiting for start, op inputs latched on start
// S_SCAN | pick lowest enabled lane at or above the current index
// S_REQ  | request held on the LSC until ready or misaligned
// S_DONE | done pulse, err valid
module rv32v_lsc_sequencer #(
    parameter int NUM_LANES  = 4,
    parameter int LANE_IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic                      i_flush,
    input  logic [1:0]                i_mode,
    input  logic                      i_is_store,
    input  logic [1:0]                i_eew,
    input  logic [31:0]               i_base_addr,
    input  logic [31:0]               i_stride,
    input  logic [NUM_LANES*32-1:0]   i_addr_wide,
    input  logic [NUM_LANES*32-1:0]   i_store_data_wide,
    input  logic [NUM_LANES-1:0]      i_ven_lanes,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_err,
    output logic [LANE_IDX_W-1:0]     o_err_lane,
    output logic [NUM_LANES*32-1:0]   o_dload_wide,
    rv32v_lsc_sequencer_if.master     io_lsc
);
    // One extra bit so the scan index can point past the last lane.
    localparam int IDX_W = LANE_IDX_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_REQ, S_DONE} state_t;

    state_t                    r_state, w_next;
    logic [1:0]                r_mode;
    logic                      r_is_store;
    logic [1:0]                r_eew;
    logic [31:0]               r_base, r_stride;
    logic [NUM_LANES*32-1:0]   r_addr_wide, r_sdata_wide, r_dload;
    logic [NUM_LANES-1:0]      r_ven;
    logic [IDX_W-1:0]          r_idx;
    logic [LANE_IDX_W-1:0]     r_lane, r_err_lane, w_sel;
    logic                      r_err, w_found;
    logic [31:0]               r_addr, r_wdata, w_addr, w_wdata, w_elem, w_ofs;

    // Descending loop so the lowest qualifying lane is the one left selected.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (r_ven[i] && (IDX_W'(i) >= r_idx)) begin
                w_found = 1'b1;
                w_sel   = LANE_IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_ofs  = 32'(w_sel);
        w_elem = r_sdata_wide[int'(w_sel)*32 +: 32];
        case (r_mode)
            2'd1:    w_addr = r_base + w_ofs * r_stride;
            2'd2:    w_addr = r_addr_wide[int'(w_sel)*32 +: 32];
            default: w_addr = r_base + (w_ofs << r_eew);
        endcase
        case (r_eew)
            2'd0:    w_wdata = {24'd0, w_elem[7:0]};
            2'd1:    w_wdata = {16'd0, w_elem[15:0]};
            default: w_wdata = w_elem;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_next = S_SCAN;
            S_SCAN: w_next = w_found ? S_REQ : S_DONE;
            S_REQ: begin
                if (io_lsc.mem_mal_addr)   w_next = S_DONE;
                else if (io_lsc.mem_ready) w_next = S_SCAN;
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (i_flush) w_next = S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_mode       <= '0;
            r_is_store   <= 1'b0;
            r_eew        <= '0;
            r_base       <= '0;
            r_stride     <= '0;
            r_addr_wide  <= '0;
            r_sdata_wide <= '0;
            r_ven        <= '0;
            r_dload      <= '0;
            r_idx        <= '0;
            r_lane       <= '0;
            r_err        <= 1'b0;
            r_err_lane   <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && i_start && !i_flush) begin
                r_mode       <= i_mode;
                r_is_store   <= i_is_store;
                r_eew        <= (i_eew == 2'd3) ? 2'd2 : i_eew;
                r_base       <= i_base_addr;
                r_stride     <= i_stride;
                r_addr_wide  <= i_addr_wide;
                r_sdata_wide <= i_store_data_wide;
                r_ven        <= i_ven_lanes;
                r_dload      <= '0;
                r_idx        <= '0;
                r_err        <= 1'b0;
                r_err_lane   <= '0;
            end
            if (r_state == S_SCAN && w_found) begin
                r_lane  <= w_sel;
                r_addr  <= w_addr;
                r_wdata <= w_wdata;
            end
            if (r_state == S_REQ) begin
                if (io_lsc.mem_mal_addr) begin
                    if (!i_flush) begin
                        r_err      <= 1'b1;
                        r_err_lane <= r_lane;
                    end
                end else if (io_lsc.mem_ready) begin
                    // A completing load is kept even if flush lands this cycle.
                    if (!r_is_store) r_dload[int'(r_lane)*32 +: 32] <= io_lsc.mem_rdata;
                    r_idx <= IDX_W'(r_lane) + IDX_W'(1);
                end
            end
            if (r_state == S_DONE) r_err <= 1'b0;
        end
    end

    assign o_busy                = (r_state == S_SCAN) || (r_state == S_REQ);
    assign o_done                = (r_state == S_DONE);
    assign o_err                 = r_err;
    assign o_err_lane            = r_err_lane;
    assign o_dload_wide          = r_dload;
    assign io_lsc.mem_ren        = (r_state == S_REQ) && !r_is_store;
    assign io_lsc.mem_wen        = (r_state == S_REQ) && r_is_store;
    assign io_lsc.mem_addr       = r_addr;
    assign io_lsc.mem_store_data = r_wdata;
    assign io_lsc.mem_load_type  = {1'b0, r_eew};
endmodule

// File: tb/tb_rv32v_lsc_sequencer.sv
module tb_rv32v_lsc_sequencer;
    localparam int NL = 4;

    typedef struct {
        logic        is_store;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  ltype;
    } acc_t;

    typedef struct {
        logic         err;
        logic [1:0]   lane;
        logic [127:0] dload;
        int           lat;
    } res_t;

    logic          clk, rst, start, flush, is_store;
    logic [1:0]    mode, eew;
    logic [31:0]   base_addr, stride;
    logic [127:0]  addr_wide, sdata_wide;
    logic [3:0]    ven;
    logic          busy, done, err;
    logic [1:0]    err_lane;
    logic [127:0]  dload;

    rv32v_lsc_sequencer_if lsc_if ();

    rv32v_lsc_sequencer #(.NUM_LANES(NL)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_flush(flush),
        .i_mode(mode), .i_is_store(is_store), .i_eew(eew),
        .i_base_addr(base_addr), .i_stride(stride),
        .i_addr_wide(addr_wide), .i_store_data_wide(sdata_wide),
        .i_ven_lanes(ven), .o_busy(busy), .o_done(done), .o_err(err),
        .o_err_lane(err_lane), .o_dload_wide(dload), .io_lsc(lsc_if)
    );

    acc_t        acc_q[$];
    res_t        res_q[$];
    int          n_checks = 0, n_fail = 0;
    int          cyc = 0, start_cyc = 0, op_acc_cnt = 0, op_delay = 0;
    logic [1:0]  op_eew = 2'd0;
    logic [31:0] salt = 32'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ salt;
    endfunction

    function automatic bit misaligned(input logic [31:0] a, input logic [1:0] w);
        return (w == 2'd1 && a[0]) || (w == 2'd2 && a[1:0] != 2'b00);
    endfunction

    // Reference model: walk the enabled lanes in order and list the accesses
    // the LSC should see, stopping at the first misaligned one.
    task automatic push_expect(input logic [1:0] md, input logic st, input logic [1:0] w,
                               input logic [31:0] b, input logic [31:0] s,
                               input logic [127:0] aw, input logic [127:0] sw,
                               input logic [3:0] en, input int d);
        acc_t        a;
        res_t        r;
        int          nacc = 0;
        logic [31:0] ad, sd;
        r.err = 1'b0; r.lane = 2'd0; r.dload = '0;
        for (int i = 0; i < NL; i++) begin
            if (!en[i]) continue;
            if (md == 2'd1)      ad = b + 32'(i) * s;
            else if (md == 2'd2) ad = aw[i*32 +: 32];
            else                 ad = b + 32'(i) * (32'd1 << w);
            sd = sw[i*32 +: 32];
            if (w == 2'd0)      sd = sd & 32'h0000_00FF;
            else if (w == 2'd1) sd = sd & 32'h0000_FFFF;
            a.is_store = st; a.addr = ad; a.data = sd; a.ltype = {1'b0, w};
            acc_q.push_back(a);
            nacc++;
            if (misaligned(ad, w)) begin
                r.err = 1'b1; r.lane = 2'(i);
                break;
            end
            if (!st) r.dload[i*32 +: 32] = rdata_of(ad);
        end
        r.lat = nacc + (r.err ? 0 : 1) + nacc * (d + 1);
        res_q.push_back(r);
    endtask

    task automatic launch(input logic [1:0] md, input logic st, input logic [1:0] w,
                          input logic [31:0] b, input logic [31:0] s,
                          input logic [127:0] aw, input logic [127:0] sw,
                          input logic [3:0] en, input int d);
        @(negedge clk);
        op_delay = d; op_eew = w; salt = $urandom; op_acc_cnt = 0;
        push_expect(md, st, w, b, s, aw, sw, en, d);
        mode = md; is_store = st; eew = w; base_addr = b; stride = s;
        addr_wide = aw; sdata_wide = sw; ven = en;
        start = 1'b1;
        start_cyc = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble op inputs so the DUT must rely on what it latched.
        mode = 2'($urandom); is_store = 1'($urandom); eew = 2'($urandom);
        base_addr = $urandom; stride = $urandom; ven = 4'($urandom);
        addr_wide = {$urandom, $urandom, $urandom, $urandom};
        sdata_wide = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_done(input bit poke);
        bit got = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (poke && busy && $urandom_range(0, 3) == 0) begin
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        check("done_seen", got, 1'b1);
    endtask

    function automatic logic [31:0] rand_addr(input logic [1:0] w);
        logic [31:0] a = $urandom;
        if ($urandom_range(0, 7) != 0) a = a & ~((32'd1 << w) - 32'd1);
        return a;
    endfunction

    // LSC model: answer each request after op_delay wait cycles; misaligned
    // requests get mal together with ready. Junk data while waiting.
    initial begin
        int cnt = 0;
        lsc_if.mem_ready = 1'b0; lsc_if.mem_mal_addr = 1'b0; lsc_if.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (lsc_if.mem_ren || lsc_if.mem_wen) begin
                if (cnt >= op_delay) begin
                    lsc_if.mem_ready    = 1'b1;
                    lsc_if.mem_mal_addr = misaligned(lsc_if.mem_addr, op_eew);
                    lsc_if.mem_rdata    = lsc_if.mem_mal_addr ? $urandom : rdata_of(lsc_if.mem_addr);
                    cnt = 0;
                end else begin
                    lsc_if.mem_ready = 1'b0; lsc_if.mem_mal_addr = 1'b0;
                    lsc_if.mem_rdata = $urandom;
                    cnt++;
                end
            end else begin
                lsc_if.mem_ready = 1'b0; lsc_if.mem_mal_addr = 1'b0;
                lsc_if.mem_rdata = $urandom;
                cnt = 0;
            end
        end
    end

    // Monitor: compare each completed access and each done against the queues.
    initial begin
        acc_t        a;
        res_t        r;
        bit          pend = 1'b0;
        logic [31:0] prev_addr = '0;
        forever begin
            @(negedge clk);
            if (lsc_if.mem_ren || lsc_if.mem_wen) begin
                if (pend) check("hold_addr", lsc_if.mem_addr, prev_addr);
                if (lsc_if.mem_ready || lsc_if.mem_mal_addr) begin
                    check("access_expected", acc_q.size() != 0, 1'b1);
                    if (acc_q.size() != 0) begin
                        a = acc_q.pop_front();
                        check("acc_wen", lsc_if.mem_wen, a.is_store);
                        check("acc_ren", lsc_if.mem_ren, !a.is_store);
                        check("acc_addr", lsc_if.mem_addr, a.addr);
                        check("acc_ltype", lsc_if.mem_load_type, a.ltype);
                        if (a.is_store) check("acc_sdata", lsc_if.mem_store_data, a.data);
                    end
                    op_acc_cnt++;
                    pend = 1'b0;
                end else begin
                    pend = 1'b1;
                    prev_addr = lsc_if.mem_addr;
                end
            end else begin
                pend = 1'b0;
            end
            if (done) begin
                check("done_expected", res_q.size() != 0, 1'b1);
                if (res_q.size() != 0) begin
                    r = res_q.pop_front();
                    check("done_err", err, r.err);
                    if (r.err) check("done_err_lane", err_lane, r.lane);
                    check("done_dload", dload, r.dload);
                    check("done_latency", 128'(cyc - start_cyc), 128'(r.lat));
                    check("done_busy_low", busy, 1'b0);
                    check("done_accs_left", 128'(acc_q.size()), 128'd0);
                end
            end
        end
    end

    // Abort an op mid-flight with flush or reset; on_ready aborts in the
    // cycle the first access completes.
    task automatic abort_op(input bit use_rst, input bit on_ready);
        bit got = 1'b0;
        launch(2'd0, 1'b0, 2'd2, 32'h3000, 32'd0, '0, '0, 4'hF, on_ready ? 0 : 4);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (on_ready ? (lsc_if.mem_ren && lsc_if.mem_ready)
                         : (lsc_if.mem_ren && !lsc_if.mem_ready && op_acc_cnt == 1)) begin
                got = 1'b1;
                break;
            end
        end
        check("abort_point_reached", got, 1'b1);
        if (use_rst) rst = 1'b1;
        else         flush = 1'b1;
        @(posedge clk);
        acc_q.delete();
        res_q.delete();
        #1;
        rst = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_ren", lsc_if.mem_ren, 1'b0);
        check("abort_wen", lsc_if.mem_wen, 1'b0);
        if (use_rst) begin
            check("rst_dload", dload, '0);
            check("rst_addr", lsc_if.mem_addr, 32'd0);
            check("rst_err", err, 1'b0);
        end else if (on_ready) begin
            check("flush_cycle_write", dload[31:0], rdata_of(32'h3000));
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [127:0] aw, sw;
        logic [1:0]   w;
        logic [31:0]  s;
        rst = 1'b1; start = 1'b0; flush = 1'b0; mode = '0; is_store = 1'b0; eew = '0;
        base_addr = '0; stride = '0; addr_wide = '0; sdata_wide = '0; ven = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_err_lane", err_lane, 2'd0);
        check("rst_dload", dload, '0);
        check("rst_ren_wen", {lsc_if.mem_ren, lsc_if.mem_wen}, 2'b00);
        check("rst_addr_data", {lsc_if.mem_addr, lsc_if.mem_store_data}, 64'd0);
        rst = 1'b0;

        launch(2'd0, 1'b0, 2'd2, 32'h1000, 32'd0, '0, '0, 4'hF, 0);
        wait_done(1'b0);

        sw = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        launch(2'd1, 1'b1, 2'd2, 32'h2000, 32'hFFFF_FFF8, '0, sw, 4'b0101, 1);
        wait_done(1'b0);

        aw = {32'h0000_5F0C, 32'h0000_4004, 32'h0000_7008, 32'h0000_1230};
        launch(2'd2, 1'b0, 2'd2, 32'd0, 32'd0, aw, '0, 4'hF, 3);
        wait_done(1'b0);

        launch(2'd0, 1'b0, 2'd2, 32'h1002, 32'd0, '0, '0, 4'hF, 0);
        wait_done(1'b0);
        start = 1'b1; ven = 4'hF;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("start_in_done_ignored", busy, 1'b0);
        repeat (3) @(negedge clk);

        launch(2'd0, 1'b0, 2'd0, 32'h4000, 32'd0, '0, '0, 4'h0, 0);
        wait_done(1'b0);

        abort_op(1'b0, 1'b0);
        launch(2'd0, 1'b1, 2'd1, 32'h6000, 32'd0, '0, sw, 4'hF, 1);
        wait_done(1'b0);
        abort_op(1'b0, 1'b1);
        abort_op(1'b1, 1'b0);
        launch(2'd1, 1'b0, 2'd0, 32'h8001, 32'd3, '0, '0, 4'b1011, 0);
        wait_done(1'b0);

        for (int n = 0; n < 40; n++) begin
            w = 2'($urandom_range(0, 2));
            s = 32'(int'($urandom_range(0, 32)) - 16) << w;
            for (int i = 0; i < NL; i++) begin
                aw[i*32 +: 32] = rand_addr(w);
                sw[i*32 +: 32] = $urandom;
            end
            launch(2'($urandom_range(0, 3)), 1'($urandom), w, rand_addr(w), s, aw, sw,
                   4'($urandom), $urandom_range(0, 3));
            wait_done(1'($urandom));
        end

        repeat (5) @(negedge clk);
        check("queues_drained", 128'(acc_q.size() + res_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
